dmem_ctrl: RTL

//  Parametrised data-memory controller: successor to the fixed word-wide, single-cycle data_mem.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_lane_align.sv | 44 ++++
 rtl/dmem_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and byte-lane helper for the data-memory controller.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Byte-lane mask for an access of the given size at byte offset lane.
    function automatic logic [3:0] be_from(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: replicates store data across lanes and
// extracts/extends load data from the addressed lanes.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wword_c,
    output logic [3:0]  be_c,
    output logic [31:0] rdata_c
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_sh = rword >> {lane, 3'b000};
    assign half_sh = rword >> {lane[1], 4'b0000};
    assign byte_v  = byte_sh[7:0];
    assign half_v  = half_sh[15:0];

    always_comb begin
        wword_c = wdata;
        be_c    = be_from(size, lane);
        rdata_c = '0;
        case (size)
            SZ_BYTE: begin
                wword_c = {4{wdata[7:0]}};
                rdata_c = {{24{sign & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                wword_c = {2{wdata[15:0]}};
                rdata_c = {{16{sign & half_v[15]}}, half_v};
            end
            SZ_WORD: rdata_c = rword;
            default: rdata_c = '0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: req/ready handshake with programmable wait states,
// byte/half/word access with lane steering, and fault detection.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned          ADDR_W      = 32,
    parameter int unsigned          DEPTH       = 1024,
    parameter logic [ADDR_W-1:0]    BASE_ADDR   = '0,
    parameter int unsigned          WAIT_CYCLES = 1,
    parameter string                INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              ready,
    output logic [31:0]       rdata,
    output logic              err
);

    localparam int unsigned       IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   SPAN    = (ADDR_W+1)'(64'(DEPTH) * 64'd4);
    localparam logic [CNT_W-1:0]  WAIT_LD = CNT_W'(WAIT_CYCLES);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               accept, commit;

    logic               we_q;
    logic [1:0]         size_q;
    logic               sign_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;

    logic [ADDR_W-1:0]  offset;
    logic               out_rng, misal, bad_sz, fault;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        rword, wword, ld_data;
    logic [3:0]         be;

    logic [31:0]        mem [DEPTH];

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // RESP also accepts so back-to-back requests sustain one access per 2+WAIT_CYCLES cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = WAIT;
                    cnt_nxt   = WAIT_LD;
                    accept    = 1'b1;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (req) begin
                    state_nxt = WAIT;
                    cnt_nxt   = WAIT_LD;
                    accept    = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            size_q  <= SZ_WORD;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= we;
            size_q  <= size;
            sign_q  <= sign;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    assign offset  = addr_q - BASE_ADDR;
    assign out_rng = (addr_q < BASE_ADDR) || ({1'b0, offset} >= SPAN);
    assign misal   = ((size_q == SZ_HALF) && addr_q[0]) ||
                     ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
    assign bad_sz  = (size_q == 2'b11);
    assign fault   = out_rng || misal || bad_sz;
    assign idx     = offset[IDX_W+1:2];
    assign rword   = mem[idx];

    dmem_lane_align u_align (
        .size    (size_q),
        .sign    (sign_q),
        .lane    (addr_q[1:0]),
        .wdata   (wdata_q),
        .rword   (rword),
        .wword_c (wword),
        .be_c    (be),
        .rdata_c (ld_data)
    );

    // Array write on the WAIT->RESP edge; contents are not reset.
    always_ff @(posedge clk) begin
        if (commit && we_q && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    // Registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy  <= 1'b0;
            ready <= 1'b0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            busy  <= (state_nxt != IDLE);
            ready <= (state_nxt == RESP);
            err   <= commit && fault;
            rdata <= (commit && !fault && !we_q) ? ld_data : '0;
        end
    end

endmodule
